// File: rtl/aes_pkg.sv
// Shared AES definitions: constants, state encoding, S-box and Rcon helpers.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam logic [7:0]  LAST_RCON  = 8'h36;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESENT = 3'd1,
    XORW    = 3'd2,
    SUBW    = 3'd3,
    MIXW    = 3'd4
  } state_t;

  // Forward S-box, entry i at index i.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Divide by x in GF(2^8): steps Rcon backwards (36, 1b, 80, 40, ..., 01).
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return r[0] ? (((r ^ 8'h1b) >> 1) | 8'h80) : (r >> 1);
  endfunction

  // Word idx of a 128-bit key; w0 is the most significant word.
  function automatic logic [31:0] get_word(input logic [127:0] k,
                                           input int unsigned idx);
    return k[127 - 32*idx -: 32];
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel S-box lookups on a 32-bit word (SubWord).
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub_word
);

  // Byte-wise substitution, purely combinational.
  always_comb begin
    sub_word = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      sub_word[8*i +: 8] = sbox(word[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// On-the-fly inverse AES-128 key expansion: emits round keys 10 down to 0.
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] last_key_i,
  input  logic         abort,
  input  logic         key_ready,
  output logic [127:0] key_o,
  output logic         key_valid,
  output logic [3:0]   round_o,
  output logic         busy,
  output logic         done
);

  state_t       state;
  logic [127:0] key_r;
  logic [3:0]   round_r;
  logic [7:0]   rcon_r;
  logic [31:0]  sub_r;
  logic         done_r;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_rot_w3;

  // Split the current key into words and rotate w3 for SubWord.
  always_comb begin
    w0     = get_word(key_r, 0);
    w1     = get_word(key_r, 1);
    w2     = get_word(key_r, 2);
    w3     = get_word(key_r, 3);
    rot_w3 = {w3[23:0], w3[31:24]};
  end

  aes_sbox_word u_sbox_word (
    .word     (rot_w3),
    .sub_word (sub_rot_w3)
  );

  // Control FSM and key datapath; each earlier key takes XORW, SUBW, MIXW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_r   <= '0;
      round_r <= '0;
      rcon_r  <= '0;
      sub_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              key_r   <= last_key_i;
              round_r <= 4'(NUM_ROUNDS);
              rcon_r  <= LAST_RCON;
              state   <= PRESENT;
            end
          end
          PRESENT: begin
            if (key_ready) begin
              if (round_r != 4'd0) begin
                round_r <= round_r - 4'd1;
                state   <= XORW;
              end else begin
                done_r <= 1'b1;
                state  <= IDLE;
              end
            end
          end
          XORW: begin
            key_r <= {w0, w1 ^ w0, w2 ^ w1, w3 ^ w2};
            state <= SUBW;
          end
          SUBW: begin
            sub_r <= sub_rot_w3;
            state <= MIXW;
          end
          MIXW: begin
            key_r  <= {w0 ^ sub_r ^ {rcon_r, 24'h0}, key_r[95:0]};
            rcon_r <= inv_xtime(rcon_r);
            state  <= PRESENT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Output view of the registered state.
  always_comb begin
    key_o     = key_r;
    round_o   = round_r;
    done      = done_r;
    key_valid = (state == PRESENT);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for the inverse AES-128 key schedule using FIPS-197 vectors.
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] last_key_i = '0;
  logic         abort = 1'b0;
  logic         key_ready = 1'b0;
  logic [127:0] key_o;
  logic         key_valid;
  logic [3:0]   round_o;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [127:0] tbl [0:10];
  logic [127:0] saved_key;
  int           t0;

  localparam logic [127:0] C10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C9  = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [127:0] C0  = 128'h000102030405060708090a0b0c0d0e0f;

  aes_inv_key_schedule dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .last_key_i (last_key_i),
    .abort      (abort),
    .key_ready  (key_ready),
    .key_o      (key_o),
    .key_valid  (key_valid),
    .round_o    (round_o),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [127:0] k);
    last_key_i = k;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_valid", 128'(key_valid), 128'(1));
    chk("load_round", 128'(round_o), 128'(10));
    chk("load_key", key_o, k);
  endtask

  // Walk keys from round 10 down to 'last'; returns just after the handshake
  // of key 'last'. pct is the key_ready probability, poke holds start high.
  task automatic run_seq(input int pct, input bit poke, input bit full,
                         input logic [127:0] k10, input logic [127:0] k9,
                         input logic [127:0] k0, input int last);
    int cnt, tries;
    bit accepted, rdy;
    logic [127:0] hold_key;
    logic [3:0] hold_r;
    logic [127:0] exp;
    for (int r = 10; r >= last; r--) begin
      cnt = 0;
      while (!key_valid && cnt < 20) begin
        start = poke;
        step();
        cnt++;
      end
      start = 1'b0;
      chk("valid", 128'(key_valid), 128'(1));
      if (r != 10) chk("latency", 128'(cnt), 128'(3));
      chk("round", 128'(round_o), 128'(r));
      exp = full ? tbl[r] : (r == 10 ? k10 : (r == 9 ? k9 : k0));
      if (full || r >= 9 || r == 0) chk($sformatf("key_r%0d", r), key_o, exp);
      accepted = 1'b0;
      tries = 0;
      while (!accepted) begin
        key_ready = (tries >= 40) || ($urandom_range(99) < pct);
        start = (r == 0) ? 1'b0 : poke;
        hold_key = key_o;
        hold_r = round_o;
        rdy = key_ready;
        step();
        tries++;
        if (rdy) accepted = 1'b1;
        else begin
          chk("stable_key", key_o, hold_key);
          chk("stable_round", 128'(round_o), 128'(hold_r));
          chk("stable_valid", 128'(key_valid), 128'(1));
        end
      end
      key_ready = 1'b0;
      start = 1'b0;
      chk("valid_drop", 128'(key_valid), 128'(0));
      if (r == 0) chk("done", 128'(done), 128'(1));
      else chk("no_done", 128'(done), 128'(0));
    end
  endtask

  initial begin
    tbl[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    tbl[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    tbl[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    tbl[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    tbl[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    tbl[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    tbl[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    tbl[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    tbl[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    tbl[9]  = 128'hac7766f319fadc2128d12941575c006e;
    tbl[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Reset values
    step();
    chk("rst_key", key_o, 128'h0);
    chk("rst_valid", 128'(key_valid), 128'(0));
    chk("rst_round", 128'(round_o), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    rst_n = 1'b1;
    step();
    chk("idle_busy", 128'(busy), 128'(0));

    // 1: FIPS-197 A.1, always ready, total latency and hold after done
    load(tbl[10]);
    t0 = cyc;
    run_seq(100, 1'b0, 1'b1, tbl[10], tbl[9], tbl[0], 0);
    chk("total_cycles", 128'(cyc - t0), 128'(41));
    step();
    chk("done_pulse", 128'(done), 128'(0));
    chk("hold_key", key_o, tbl[0]);
    chk("hold_busy", 128'(busy), 128'(0));

    // 2: FIPS-197 C.1
    load(C10);
    run_seq(100, 1'b0, 1'b0, C10, C9, C0, 0);

    // 3: backpressure
    load(tbl[10]);
    run_seq(30, 1'b0, 1'b1, tbl[10], tbl[9], tbl[0], 0);

    // 4: start held during the sequence is ignored; start after done reloads
    load(tbl[10]);
    run_seq(60, 1'b1, 1'b1, tbl[10], tbl[9], tbl[0], 0);
    load(tbl[10]);
    run_seq(100, 1'b0, 1'b1, tbl[10], tbl[9], tbl[0], 0);

    // 5: abort with start in IDLE, then abort in SUBW at round 6
    step();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_idle_busy", 128'(busy), 128'(0));
    chk("abort_idle_valid", 128'(key_valid), 128'(0));
    load(tbl[10]);
    run_seq(100, 1'b0, 1'b1, tbl[10], tbl[9], tbl[0], 7);
    chk("pre_abort_round", 128'(round_o), 128'(6));
    step();
    chk("pre_abort_busy", 128'(busy), 128'(1));
    saved_key = key_o;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", 128'(key_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_key_kept", key_o, saved_key);
    step();
    step();
    chk("post_abort_done", 128'(done), 128'(0));
    chk("post_abort_busy", 128'(busy), 128'(0));
    load(tbl[10]);
    run_seq(100, 1'b0, 1'b1, tbl[10], tbl[9], tbl[0], 0);

    // 6: asynchronous reset mid-sequence
    load(tbl[10]);
    run_seq(100, 1'b0, 1'b1, tbl[10], tbl[9], tbl[0], 5);
    chk("pre_rst_round", 128'(round_o), 128'(4));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_key", key_o, 128'h0);
    chk("arst_valid", 128'(key_valid), 128'(0));
    chk("arst_round", 128'(round_o), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_done", 128'(done), 128'(0));
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("post_rst_busy", 128'(busy), 128'(0));
    chk("post_rst_valid", 128'(key_valid), 128'(0));
    chk("post_rst_done", 128'(done), 128'(0));
    load(tbl[10]);
    run_seq(100, 1'b0, 1'b1, tbl[10], tbl[9], tbl[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
